// File: rtl/finv_nr_ctrl_if.sv
// Request/result and shared fmul/fsub handshake bundle for finv_nr_ctrl.
// slave: the controller side; master: requester plus the arithmetic units.
interface finv_nr_ctrl_if;
    logic [31:0] x;
    logic        ready;
    logic [31:0] y;
    logic        valid;
    logic        busy;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [31:0] mul_y;
    logic        mul_valid;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_ready;
    logic [31:0] sub_y;
    logic        sub_valid;

    modport slave (
        input  x, ready, mul_y, mul_valid, sub_y, sub_valid,
        output y, valid, busy, mul_a, mul_b, mul_ready, sub_a, sub_b, sub_ready
    );

    modport master (
        output x, ready, mul_y, mul_valid, sub_y, sub_valid,
        input  y, valid, busy, mul_a, mul_b, mul_ready, sub_a, sub_b, sub_ready
    );
endinterface

// File: rtl/finv_nr_ctrl.sv
// Newton-Raphson 1/x sequencer driving a shared external fmul and fsub.
// Optional FINV_NR_SPECIAL_EN: zero/inf/NaN-exponent inputs bypass the iterations.
module finv_nr_ctrl #(
    parameter int unsigned ITER = 2
) (
    input  logic          clk,
    input  logic          rst,
    finv_nr_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, SEED, M1_ISS, M1_WAIT, S_ISS, S_WAIT, M2_ISS, M2_WAIT, DONE
    } state_t;

    state_t      state;
    logic [31:0] xr;
    logic [31:0] yr;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nx;
    logic [8:0]  seed_e;
    logic [31:0] seed;

    function automatic logic [5:0] seed_mant(input logic [5:0] idx);
        logic [5:0] m;
        case (idx)
            6'd0:  m = 6'd0;   6'd1:  m = 6'd62;  6'd2:  m = 6'd60;  6'd3:  m = 6'd58;
            6'd4:  m = 6'd56;  6'd5:  m = 6'd55;  6'd6:  m = 6'd53;  6'd7:  m = 6'd51;
            6'd8:  m = 6'd50;  6'd9:  m = 6'd48;  6'd10: m = 6'd47;  6'd11: m = 6'd45;
            6'd12: m = 6'd44;  6'd13: m = 6'd42;  6'd14: m = 6'd41;  6'd15: m = 6'd40;
            6'd16: m = 6'd38;  6'd17: m = 6'd37;  6'd18: m = 6'd36;  6'd19: m = 6'd35;
            6'd20: m = 6'd34;  6'd21: m = 6'd32;  6'd22: m = 6'd31;  6'd23: m = 6'd30;
            6'd24: m = 6'd29;  6'd25: m = 6'd28;  6'd26: m = 6'd27;  6'd27: m = 6'd26;
            6'd28: m = 6'd25;  6'd29: m = 6'd24;  6'd30: m = 6'd23;  6'd31: m = 6'd22;
            6'd32: m = 6'd21;  6'd33: m = 6'd20;  6'd34: m = 6'd20;  6'd35: m = 6'd19;
            6'd36: m = 6'd18;  6'd37: m = 6'd17;  6'd38: m = 6'd16;  6'd39: m = 6'd16;
            6'd40: m = 6'd15;  6'd41: m = 6'd14;  6'd42: m = 6'd13;  6'd43: m = 6'd13;
            6'd44: m = 6'd12;  6'd45: m = 6'd11;  6'd46: m = 6'd10;  6'd47: m = 6'd10;
            6'd48: m = 6'd9;   6'd49: m = 6'd8;   6'd50: m = 6'd8;   6'd51: m = 6'd7;
            6'd52: m = 6'd7;   6'd53: m = 6'd6;   6'd54: m = 6'd5;   6'd55: m = 6'd5;
            6'd56: m = 6'd4;   6'd57: m = 6'd4;   6'd58: m = 6'd3;   6'd59: m = 6'd3;
            6'd60: m = 6'd2;   6'd61: m = 6'd2;   6'd62: m = 6'd1;   default: m = 6'd1;
        endcase
        return m;
    endfunction

    // Table holds round(2/(1+i/64)) fraction bits; index 0 is exactly 1.0, hence the exponent bump.
    always_comb begin
        seed_e = 9'd253 - {1'b0, xr[30:23]} + {8'd0, (xr[22:17] == 6'd0)};
        seed   = {xr[31], seed_e[7:0], seed_mant(xr[22:17]), 17'd0};
        cnt_nx = cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            xr            <= '0;
            yr            <= '0;
            cnt           <= '0;
            bus.y         <= '0;
            bus.valid     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.mul_ready <= 1'b0;
            bus.sub_a     <= '0;
            bus.sub_b     <= '0;
            bus.sub_ready <= 1'b0;
        end else begin
            bus.mul_ready <= 1'b0;
            bus.sub_ready <= 1'b0;
            bus.valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ready) begin
                        xr       <= bus.x;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SEED;
                    end
                end
                SEED: begin
`ifdef FINV_NR_SPECIAL_EN
                    if (xr[30:23] == 8'h00) begin
                        yr        <= {xr[31], 8'hFF, 23'd0};
                        bus.y     <= {xr[31], 8'hFF, 23'd0};
                        bus.valid <= 1'b1;
                        state     <= DONE;
                    end else if (xr[30:23] == 8'hFF) begin
                        yr        <= {xr[31], 31'd0};
                        bus.y     <= {xr[31], 31'd0};
                        bus.valid <= 1'b1;
                        state     <= DONE;
                    end else
`endif
                    begin
                        yr            <= seed;
                        bus.mul_a     <= xr;
                        bus.mul_b     <= seed;
                        bus.mul_ready <= 1'b1;
                        state         <= M1_ISS;
                    end
                end
                M1_ISS, M1_WAIT: begin
                    if (bus.mul_valid) begin
                        bus.sub_a     <= 32'h4000_0000;
                        bus.sub_b     <= bus.mul_y;
                        bus.sub_ready <= 1'b1;
                        state         <= S_ISS;
                    end else begin
                        state <= M1_WAIT;
                    end
                end
                S_ISS, S_WAIT: begin
                    if (bus.sub_valid) begin
                        bus.mul_a     <= yr;
                        bus.mul_b     <= bus.sub_y;
                        bus.mul_ready <= 1'b1;
                        state         <= M2_ISS;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                M2_ISS, M2_WAIT: begin
                    if (bus.mul_valid) begin
                        yr  <= bus.mul_y;
                        cnt <= cnt_nx;
                        // y and valid are loaded on DONE entry so valid is high during DONE itself.
                        if (32'(cnt_nx) == ITER) begin
                            bus.y     <= bus.mul_y;
                            bus.valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus.mul_a     <= xr;
                            bus.mul_b     <= bus.mul_y;
                            bus.mul_ready <= 1'b1;
                            state         <= M1_ISS;
                        end
                    end else begin
                        state <= M2_WAIT;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
